// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the burst-fill write-through cache controller.
package cache_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        READ,
        RD_ISSUE,
        RD_WAIT,
        RD_DATA,
        WRITE,
        WR_ISSUE,
        WR_WAIT,
        WR_DATA
    } cache_state_t;

    // A one-word line still needs a 1-bit index port.
    function automatic int fill_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_burst_wait_ctr.sv
// Memory wait-state down-counter: load on issue, count down to zero, then hold.
module wait_ctr #(
    parameter int CTR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    output logic             done
);

    logic [CTR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CTR_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cache_ctrl_burst.sv
// Direct-mapped write-through cache control FSM with multi-word line fill.
// Optional statistics counters are built when CACHE_CTRL_STATS_EN is defined.
module cache_ctrl_burst
    import cache_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int LINE_WORDS  = 4,
    parameter int CTR_W       = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            strobe,
    input  logic                            drw,
    input  logic                            m,
    input  logic                            v,
    output logic                            d_ready,
    output logic                            w,
    output logic                            m_strobe,
    output logic                            m_rw,
    output logic                            r_sel,
    output logic                            w_sel,
    output logic [fill_w(LINE_WORDS)-1:0]   fill_idx,
    output logic                            busy
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                     rd_hit_cnt,
    output logic [31:0]                     rd_miss_cnt,
    output logic [31:0]                     wr_cnt
`endif
);

    localparam int FW = fill_w(LINE_WORDS);
    localparam logic [FW-1:0]    LAST_IDX = FW'(LINE_WORDS - 1);
    localparam logic [CTR_W-1:0] WAIT_LD  = CTR_W'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1 || (WAIT_CYCLES - 1) >= (1 << CTR_W)) begin : g_bad_wait
            $error("cache_ctrl_burst: WAIT_CYCLES-1 does not fit in CTR_W bits");
        end
        if (LINE_WORDS < 1 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_line
            $error("cache_ctrl_burst: LINE_WORDS must be a power of two");
        end
    endgenerate

    cache_state_t state, state_next;
    logic         hit;
    logic         hit_q;
    logic         ctr_load;
    logic         ctr_done;

    assign hit = m && v;

    wait_ctr #(
        .CTR_W(CTR_W)
    ) u_wait_ctr (
        .clk     (clk),
        .reset   (reset),
        .load    (ctr_load),
        .load_val(WAIT_LD),
        .done    (ctr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write hit status is captured in WRITE since m/v may change once memory is busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= 1'b0;
        end else if (state == WRITE) begin
            hit_q <= hit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_idx <= '0;
        end else if (state == READ && !hit) begin
            fill_idx <= '0;
        end else if (state == RD_DATA) begin
            fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + FW'(1);
        end
    end

    always_comb begin
        state_next = state;
        d_ready    = 1'b0;
        w          = 1'b0;
        m_strobe   = 1'b0;
        m_rw       = 1'b0;
        r_sel      = 1'b0;
        w_sel      = 1'b0;
        ctr_load   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (strobe) begin
                    state_next = drw ? WRITE : READ;
                end
            end
            READ: begin
                if (hit) begin
                    d_ready    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                m_strobe   = 1'b1;
                ctr_load   = 1'b1;
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (ctr_done) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                w     = 1'b1;
                w_sel = 1'b1;
                if (fill_idx == LAST_IDX) begin
                    d_ready    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RD_ISSUE;
                end
            end
            WRITE: begin
                state_next = WR_ISSUE;
            end
            WR_ISSUE: begin
                m_strobe   = 1'b1;
                m_rw       = 1'b1;
                ctr_load   = 1'b1;
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                m_rw = 1'b1;
                if (ctr_done) begin
                    state_next = WR_DATA;
                end
            end
            WR_DATA: begin
                m_rw       = 1'b1;
                d_ready    = 1'b1;
                w          = hit_q;
                r_sel      = hit_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hit_cnt  <= '0;
            rd_miss_cnt <= '0;
            wr_cnt      <= '0;
        end else begin
            if (state == READ && hit && rd_hit_cnt != 32'hFFFF_FFFF) begin
                rd_hit_cnt <= rd_hit_cnt + 32'd1;
            end
            if (state == READ && !hit && rd_miss_cnt != 32'hFFFF_FFFF) begin
                rd_miss_cnt <= rd_miss_cnt + 32'd1;
            end
            if (state == WR_DATA && wr_cnt != 32'hFFFF_FFFF) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Self-checking bench for cache_ctrl_burst: three builds (4/4, 2/4, 1/1) share stimulus, one is observed at a time.
module tb_cache_ctrl_burst;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       strobe = 1'b0;
    logic       drw = 1'b0;
    logic       m = 1'b0;
    logic       v = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [2:0] strobe_g, d_ready_v, w_v, m_strobe_v, m_rw_v, r_sel_v, w_sel_v, busy_v;
    logic [1:0] fi0, fi1;
    logic [0:0] fi2;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hc [3];
    logic [31:0] mc [3];
    logic [31:0] wc [3];
`endif

    logic       d_ready_o, w_o, m_strobe_o, m_rw_o, r_sel_o, w_sel_o, busy_o;
    logic [1:0] fill_idx_o;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] fill_q[$];
    int         exp_hit = 0, exp_miss = 0, exp_wr = 0;

    always #5 clk = ~clk;

    assign strobe_g[0] = strobe && (sel == 2'd0);
    assign strobe_g[1] = strobe && (sel == 2'd1);
    assign strobe_g[2] = strobe && (sel == 2'd2);

    cache_ctrl_burst #(.WAIT_CYCLES(4), .LINE_WORDS(4), .CTR_W(8)) dut_a (
        .clk(clk), .reset(reset), .strobe(strobe_g[0]), .drw(drw), .m(m), .v(v),
        .d_ready(d_ready_v[0]), .w(w_v[0]), .m_strobe(m_strobe_v[0]), .m_rw(m_rw_v[0]),
        .r_sel(r_sel_v[0]), .w_sel(w_sel_v[0]), .fill_idx(fi0), .busy(busy_v[0])
`ifdef CACHE_CTRL_STATS_EN
        , .rd_hit_cnt(hc[0]), .rd_miss_cnt(mc[0]), .wr_cnt(wc[0])
`endif
    );

    cache_ctrl_burst #(.WAIT_CYCLES(2), .LINE_WORDS(4), .CTR_W(8)) dut_b (
        .clk(clk), .reset(reset), .strobe(strobe_g[1]), .drw(drw), .m(m), .v(v),
        .d_ready(d_ready_v[1]), .w(w_v[1]), .m_strobe(m_strobe_v[1]), .m_rw(m_rw_v[1]),
        .r_sel(r_sel_v[1]), .w_sel(w_sel_v[1]), .fill_idx(fi1), .busy(busy_v[1])
`ifdef CACHE_CTRL_STATS_EN
        , .rd_hit_cnt(hc[1]), .rd_miss_cnt(mc[1]), .wr_cnt(wc[1])
`endif
    );

    cache_ctrl_burst #(.WAIT_CYCLES(1), .LINE_WORDS(1), .CTR_W(8)) dut_c (
        .clk(clk), .reset(reset), .strobe(strobe_g[2]), .drw(drw), .m(m), .v(v),
        .d_ready(d_ready_v[2]), .w(w_v[2]), .m_strobe(m_strobe_v[2]), .m_rw(m_rw_v[2]),
        .r_sel(r_sel_v[2]), .w_sel(w_sel_v[2]), .fill_idx(fi2), .busy(busy_v[2])
`ifdef CACHE_CTRL_STATS_EN
        , .rd_hit_cnt(hc[2]), .rd_miss_cnt(mc[2]), .wr_cnt(wc[2])
`endif
    );

    assign d_ready_o  = d_ready_v[sel];
    assign w_o        = w_v[sel];
    assign m_strobe_o = m_strobe_v[sel];
    assign m_rw_o     = m_rw_v[sel];
    assign r_sel_o    = r_sel_v[sel];
    assign w_sel_o    = w_sel_v[sel];
    assign busy_o     = busy_v[sel];
    assign fill_idx_o = (sel == 2'd0) ? fi0 : (sel == 2'd1) ? fi1 : {1'b0, fi2};

    function automatic int cfg_w(input logic [1:0] s);
        return (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    endfunction

    function automatic int cfg_l(input logic [1:0] s);
        return (s == 2'd2) ? 1 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %0h expected %0h", tag, sel, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, {24'd0, d_ready_o, w_o, m_strobe_o, m_rw_o, r_sel_o, w_sel_o, busy_o, |fill_idx_o}, 32'd0);
    endtask

    // One CPU access: push expectations, then watch the DUT until d_ready.
    task automatic do_access(input logic [1:0] s, input logic drw_i, input logic m_i,
                             input logic v_i, input bit hold);
        int wt, ln, c, n_strb, n_w, bad, exp_c;
        bit hit, seen;
        logic [31:0] exp_f;
        sel = s;
        wt  = cfg_w(s);
        ln  = cfg_l(s);
        hit = m_i && v_i;
        @(negedge clk);
        check("idle_before", {31'd0, busy_o}, 32'd0);
        drw = drw_i; m = m_i; v = v_i; strobe = 1'b1;
        if (drw_i) begin
            exp_q.push_back(32'(wt + 3));
        end else if (hit) begin
            exp_q.push_back(32'd1);
        end else begin
            exp_q.push_back(32'(1 + ln * (wt + 2)));
            for (int k = 0; k < ln; k++) fill_q.push_back(32'(k));
        end
        if (s == 2'd0) begin
            if (drw_i) exp_wr++;
            else if (hit) exp_hit++;
            else exp_miss++;
        end
        @(posedge clk);
        if (!hold) #1 strobe = 1'b0;
        c = 0; n_strb = 0; n_w = 0; bad = 0; seen = 1'b0;
        while (!seen && c < 200) begin
            @(negedge clk);
            c++;
            if (r_sel_o && w_sel_o) bad++;
            if (!drw_i && m_rw_o) bad++;
            if (m_strobe_o) begin
                n_strb++;
                exp_c = drw_i ? 2 : 2 + (n_strb - 1) * (wt + 2);
                check("strobe_cycle", 32'(c), 32'(exp_c));
                check("strobe_rw", {31'd0, m_rw_o}, {31'd0, drw_i});
            end
            if (w_o) begin
                n_w++;
                if (drw_i) begin
                    check("wr_sel", {30'd0, w_sel_o, r_sel_o}, 32'd1);
                end else begin
                    exp_f = (fill_q.size() > 0) ? fill_q.pop_front() : 32'hDEAD;
                    check("fill_sel", {30'd0, w_sel_o, r_sel_o}, 32'd2);
                    check("fill_idx", {30'd0, fill_idx_o}, exp_f);
                end
            end
            if (d_ready_o) begin
                seen = 1'b1;
                strobe = 1'b0;
                check("latency", 32'(c), (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD);
                check("done_rw", {31'd0, m_rw_o}, {31'd0, drw_i});
            end
        end
        check("d_ready_seen", {31'd0, seen}, 32'd1);
        check("strobe_count", 32'(n_strb), 32'(drw_i ? 1 : (hit ? 0 : ln)));
        check("w_count", 32'(n_w), 32'(drw_i ? (hit ? 1 : 0) : (hit ? 0 : ln)));
        check("output_rules", 32'(bad), 32'd0);
        @(negedge clk);
        check_quiet("idle_after");
    endtask

    // Start a default-build read miss and reset it in RD_WAIT of the third word.
    task automatic reset_mid_fill();
        int c, n_strb;
        sel = 2'd0;
        @(negedge clk);
        drw = 1'b0; m = 1'b0; v = 1'b1; strobe = 1'b1;
        @(posedge clk);
        #1 strobe = 1'b0;
        c = 0; n_strb = 0;
        while (n_strb < 3 && c < 200) begin
            @(negedge clk);
            c++;
            if (m_strobe_o) n_strb++;
        end
        check("rst_reach_third", 32'(n_strb), 32'd3);
        @(negedge clk);
        check("rst_fill_idx", {30'd0, fill_idx_o}, 32'd2);
        check("rst_in_wait", {30'd0, busy_o, m_strobe_o}, 32'd2);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_quiet("rst_outputs");
        exp_hit = 0; exp_miss = 0; exp_wr = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1 check_quiet("reset_state");
        end
        reset = 1'b0;

        do_access(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        do_access(2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_access(2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_access(2'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_access(2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_access(2'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        reset_mid_fill();
        do_access(2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_access(2'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        do_access(2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        do_access(2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_access(2'd1, 1'b0, 1'b0, 1'b1, 1'b1);

        do_access(2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        do_access(2'd2, 1'b0, 1'b1, 1'b1, 1'b1);
        do_access(2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        do_access(2'd2, 1'b1, 1'b0, 1'b1, 1'b1);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("fill_q_drained", 32'(fill_q.size()), 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        sel = 2'd0;
        check("stat_rd_hit", hc[0], 32'(exp_hit));
        check("stat_rd_miss", mc[0], 32'(exp_miss));
        check("stat_wr", wc[0], 32'(exp_wr));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
